// File: rtl/gpu_instruction_fifo_if.sv
// Handshake bundle between the instruction decoder (master) and the instruction FIFO (slave).
// Field widths default here unless gpu_definitions provides them earlier in the compile.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 10
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

interface gpu_instruction_fifo_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [`WIDTH_BITS-1:0]   x1_i, x2_i, rad_i;
  logic [`HEIGHT_BITS-1:0]  y1_i, y2_i;
  logic [`CHANNEL_BITS-1:0] r_i, g_i, b_i;
  logic                     write_enable_i;
  logic                     push_instruction_i;

  logic [`WIDTH_BITS-1:0]   x1_o, x2_o, rad_o;
  logic [`HEIGHT_BITS-1:0]  y1_o, y2_o;
  logic [`CHANNEL_BITS-1:0] r_o, g_o, b_o;
  logic                     we_o;
  logic                     inst_valid_o;
  logic                     inst_ready_i;
  logic [CW-1:0]            count_o;
  logic                     full_o;
  logic                     overflow_o;

  modport master (
    output x1_i, x2_i, rad_i, y1_i, y2_i, r_i, g_i, b_i, write_enable_i,
           push_instruction_i, inst_ready_i,
    input  x1_o, x2_o, rad_o, y1_o, y2_o, r_o, g_o, b_o, we_o,
           inst_valid_o, count_o, full_o, overflow_o
  );

  modport slave (
    input  x1_i, x2_i, rad_i, y1_i, y2_i, r_i, g_i, b_i, write_enable_i,
           push_instruction_i, inst_ready_i,
    output x1_o, x2_o, rad_o, y1_o, y2_o, r_o, g_o, b_o, we_o,
           inst_valid_o, count_o, full_o, overflow_o
  );
endinterface

// File: rtl/gpu_instruction_fifo.sv
// Show-ahead FIFO of decoded draw packets between the decoder and the rasterizer.
// Outputs depend only on registered state; overflow is sticky until reset.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 10
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_instruction_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  gpu_instruction_fifo_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [`WIDTH_BITS-1:0]   x1;
    logic [`HEIGHT_BITS-1:0]  y1;
    logic [`WIDTH_BITS-1:0]   x2;
    logic [`HEIGHT_BITS-1:0]  y2;
    logic [`WIDTH_BITS-1:0]   rad;
    logic [`CHANNEL_BITS-1:0] r;
    logic [`CHANNEL_BITS-1:0] g;
    logic [`CHANNEL_BITS-1:0] b;
    logic                     we;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          valid, full, pop, push;

  assign valid = (count_q != '0);
  assign full  = (count_q == DEPTH_C);
  assign pop   = valid & bus.inst_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push  = bus.push_instruction_i & (~full | pop);

  always_comb begin
    wr_entry = '{x1: bus.x1_i, y1: bus.y1_i, x2: bus.x2_i, y2: bus.y2_i,
                 rad: bus.rad_i, r: bus.r_i, g: bus.g_i, b: bus.b_i,
                 we: bus.write_enable_i};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.push_instruction_i & full & ~pop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head             = mem_q[rd_ptr_q];
  assign bus.x1_o         = head.x1;
  assign bus.y1_o         = head.y1;
  assign bus.x2_o         = head.x2;
  assign bus.y2_o         = head.y2;
  assign bus.rad_o        = head.rad;
  assign bus.r_o          = head.r;
  assign bus.g_o          = head.g;
  assign bus.b_o          = head.b;
  assign bus.we_o         = head.we;
  assign bus.inst_valid_o = valid;
  assign bus.count_o      = count_q;
  assign bus.full_o       = full;
  assign bus.overflow_o   = ovf_q;
endmodule
